// File: rtl/loader_pkg.sv
// Shared types and frame-field widths for the program loader.
package loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CHK_W  = 8;
    localparam int unsigned BCNT_W = 2;

    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN0   = 3'd1,
        LEN1   = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        LAUNCH = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and processor control.
interface program_loader_if
    import loader_pkg::*;
;
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              start;
    logic              done;
    logic              error;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_hold, start, done, error
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output cpu_hold, start, done, error
    );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Collects four bytes little-endian into a word and pulses word_valid_o the cycle after the 4th.
module byte_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [BCNT_W-1:0] byte_cnt_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    localparam int unsigned SR_W = WORD_W - BYTE_W;

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;

    // Next-state: shift bytes in from the top so the first byte lands at [7:0].
    always_comb begin
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (byte_valid_i) begin
            cnt_d = BCNT_W'(cnt_q + 1'b1);
            sr_d  = {byte_i, sr_q[SR_W-1:BYTE_W]};
            if (cnt_q == BCNT_W'(3)) begin
                word_d       = {byte_i, sr_q};
                word_valid_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            sr_q         <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign byte_cnt_o   = cnt_q;
    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/program_loader.sv
// Receives a framed program over a byte stream, writes it to instruction memory and launches the CPU.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned       ADDR_W = 10,
    parameter logic [BYTE_W-1:0] SYNC   = SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);

    localparam int unsigned CAP = 32'd1 << ADDR_W;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CHK_W-1:0]   chk_q, chk_d;
    logic [ADDR_W-1:0]  widx_q, widx_d;
    logic [WORD_W-1:0]  addr_q, addr_d;
    logic               rx_ready_q, rx_ready_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               accept_c;
    logic               asm_clear_c;
    logic               asm_valid_c;
    logic [BCNT_W-1:0]  byte_cnt;
    logic [WORD_W-1:0]  asm_word;
    logic               asm_word_valid;
    logic [LEN_W-1:0]   len_full_c;
    logic               last_word_c;

    assign accept_c    = bus.rx_valid & rx_ready_q;
    assign len_full_c  = {bus.rx_data, len_q[BYTE_W-1:0]};
    assign last_word_c = (32'(widx_q) + 32'd1) == 32'(len_q);

    byte_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clear_c),
        .byte_valid_i (asm_valid_c),
        .byte_i       (bus.rx_data),
        .byte_cnt_o   (byte_cnt),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    // Frame FSM, checksum and word-address tracking; outputs decoded from next state.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        chk_d       = chk_q;
        widx_d      = widx_q;
        addr_d      = addr_q;
        asm_clear_c = 1'b0;
        asm_valid_c = 1'b0;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (accept_c && (bus.rx_data == SYNC)) begin
                    state_d     = LEN0;
                    len_d       = '0;
                    chk_d       = '0;
                    widx_d      = '0;
                    asm_clear_c = 1'b1;
                end
            end
            LEN0: begin
                if (accept_c) begin
                    len_d[BYTE_W-1:0] = bus.rx_data;
                    state_d           = LEN1;
                end
            end
            LEN1: begin
                if (accept_c) begin
                    len_d = len_full_c;
                    if (len_full_c == '0) begin
                        state_d = CHECK;
                    end else if (32'(len_full_c) > CAP) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept_c) begin
                    asm_valid_c = 1'b1;
                    chk_d       = chk_q ^ bus.rx_data;
                    if (byte_cnt == BCNT_W'(3)) begin
                        addr_d = WORD_W'(32'(widx_q) << 2);
                        widx_d = ADDR_W'(widx_q + 1'b1);
                        if (last_word_c) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept_c) begin
                    state_d = (bus.rx_data == chk_q) ? LAUNCH : ERROR;
                end
            end
            LAUNCH: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rx_ready_d = (state_d != LAUNCH);
        cpu_hold_d = (state_d != LAUNCH) && (state_d != DONE);
        start_d    = (state_d == LAUNCH);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERROR);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            chk_q      <= '0;
            widx_q     <= '0;
            addr_q     <= '0;
            rx_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            chk_q      <= chk_d;
            widx_q     <= widx_d;
            addr_q     <= addr_d;
            rx_ready_q <= rx_ready_d;
            cpu_hold_q <= cpu_hold_d;
            start_q    <= start_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = asm_word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = asm_word;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.start      = start_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width (capacity 2**ADDR_W words).
REQ-002 Parameter SYNC, default 8'hA5, frame start byte.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_valid  input  1  byte-stream valid.
REQ-006 rx_data  input  8  byte-stream data.
REQ-007 rx_ready  output  1  byte accepted when rx_valid & rx_ready.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  32  byte address of the word written (word index * 4).
REQ-010 imem_wdata  output  32  word written.
REQ-011 cpu_hold  output  1  holds the processor idle while a program is being loaded.
REQ-012 start  output  1  one-cycle pulse that launches the processor.
REQ-013 done  output  1  last frame loaded and launched.
REQ-014 error  output  1  last frame rejected.

Function
REQ-015 Frame format SHALL be SYNC, LEN_LO, LEN_HI, LEN*4 data bytes, CHK; LEN is a 16-bit word count.
REQ-016 Words SHALL be assembled little-endian: the first data byte of each word goes to bits [7:0].
REQ-017 CHK SHALL equal the XOR of all data bytes (0x00 when LEN=0).
REQ-018 FSM states: IDLE, LEN0, LEN1, DATA, CHECK, LAUNCH, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR: a byte equal to SYNC SHALL go to LEN0, clear done/error and set cpu_hold the next cycle; other bytes are discarded with no state change.
REQ-020 LEN0 -> LEN1 on one byte; LEN1 -> DATA on one byte if LEN>0, CHECK if LEN=0, ERROR if LEN > 2**ADDR_W.
REQ-021 DATA: the 4th byte of word k accepted at cycle N SHALL produce imem_we=1, imem_addr=4k, imem_wdata=word at cycle N+1, with no bubble on rx_ready.
REQ-022 DATA -> CHECK after byte 4*LEN is accepted; CHECK accepts one byte: match -> LAUNCH, mismatch -> ERROR.
REQ-023 LAUNCH SHALL last exactly one cycle with start=1 and cpu_hold=0, then go to DONE with done=1.
REQ-024 rx_ready SHALL be 1 in every state except LAUNCH.
REQ-025 The word index SHALL be ADDR_W bits wide and never wrap within a frame (guaranteed by REQ-020).
REQ-026 ERROR: error=1 and cpu_hold=1 until the next SYNC; no start pulse in a rejected frame.
REQ-027 Words already written before an ERROR SHALL remain written; the loader does not roll back memory.
REQ-028 A SYNC-valued byte inside LEN/DATA/CHECK SHALL be treated as ordinary data, with no resync.

Reset
REQ-029 On reset assertion, regardless of mid-frame position: state=IDLE; imem_we=0, imem_addr=0, imem_wdata=0, start=0, done=0, error=0, cpu_hold=1, rx_ready=1; checksum, byte and word counters cleared.
REQ-030 After reset release the processor SHALL stay held until a valid frame launches it.

Structure
REQ-031 Shared package loader_pkg SHALL hold the state enum, the SYNC default and the frame-field widths (LEN 16, CHK 8).
REQ-032 One sub-module byte_assembler (byte shift-in, 2-bit byte counter, word_valid pulse) SHALL be instantiated; the FSM, checksum and address counter live in program_loader.

Verification
REQ-033 Frame A5 02 00 | 11 22 33 44 | 55 66 77 88 | CHK=0x88 -> writes addr 0 = 0x44332211, addr 4 = 0x88776655, one start pulse, done=1, cpu_hold=0.
REQ-034 Same frame with CHK=0x00 -> two writes occur, error=1, no start, cpu_hold stays 1.
REQ-035 A5 00 00 00 -> no imem_we, start pulse, done=1; A5 00 00 01 -> error=1.
REQ-036 ADDR_W=4, LEN=17 -> ERROR after LEN_HI with no writes; LEN=16 -> last write at addr 60.
REQ-037 Reset asserted after the 6th data byte -> all outputs at reset values; a following clean frame loads correctly.
REQ-038 Idle garbage 00 FF 5A before A5, plus rx_valid gaps between data bytes -> identical writes to REQ-033.
